mor_key_decoder: RTL and testbench

- Upstream stage of the Morse code detector.
- Converts a raw key line (high = tone/mark, low = silence/gap) into single-cycle symbol pulses by timing mark and gap durations against a programmable time unit.
- Outputs drive the detector's dot_inp, dash_inp, char_space_inp and word_space_inp directly, on the same clk.
- Includes its own input synchronizer and an overlong-mark error flag.

---
 rtl/mor_pkg.sv | 17 +
 rtl/mor_sync.sv | 22 ++
 rtl/mor_key_decoder.sv | 111 +++++++++++
 tb/tb_mor_key_decoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor_pkg.sv
// Shared types and timing multipliers for the Morse key decoder.
// Used by the decoder RTL and by reference models of it.
package mor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      GAP
   } state_t;

   // Durations in Morse time units
   localparam int DASH_UNITS = 2;
   localparam int CHAR_UNITS = 2;
   localparam int WORD_UNITS = 5;
   localparam int ERR_UNITS  = 7;

endpackage

// File: rtl/mor_sync.sv
// Two-flop synchronizer for the raw key line.
// Ports: clk, rst (async active-low), d (async in), q (synced out).
module mor_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/mor_key_decoder.sv
// Times key mark/gap lengths and emits one-cycle symbol pulses.
// Ports: clk, rst (async active-low), key_in (raw key, 1 = mark),
//   dot_out, dash_out, char_space_out, word_space_out, err_out.
module mor_key_decoder
   import mor_pkg::*;
#(
   parameter int UNIT_CYCLES = 4,
   parameter int CW = $clog2(7*UNIT_CYCLES+1)
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic dot_out,
   output logic dash_out,
   output logic char_space_out,
   output logic word_space_out,
   output logic err_out
);

   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [CW-1:0] DASH_T = CW'(DASH_UNITS*UNIT_CYCLES);
   localparam logic [CW-1:0] CHAR_T = CW'(CHAR_UNITS*UNIT_CYCLES);
   localparam logic [CW-1:0] WORD_T = CW'(WORD_UNITS*UNIT_CYCLES);
   localparam logic [CW-1:0] ERR_T  = CW'(ERR_UNITS*UNIT_CYCLES);

   logic          key_s;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dot_d, dash_d, char_d, word_d, err_d;

   mor_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (key_in),
      .q   (key_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dot_d   = 1'b0;
      dash_d  = 1'b0;
      char_d  = 1'b0;
      word_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key_s) begin
               state_d = MARK;
               cnt_d   = ONE;
            end
         end
         MARK: begin
            if (key_s) begin
               // Saturate so an overlong mark stays classified as error
               if (cnt_q != ERR_T)
                  cnt_d = cnt_q + ONE;
            end else begin
               state_d = GAP;
               cnt_d   = ONE;
               if (cnt_q >= ERR_T)
                  err_d = 1'b1;
               else if (cnt_q >= DASH_T)
                  dash_d = 1'b1;
               else
                  dot_d = 1'b1;
            end
         end
         GAP: begin
            // Word gap wins over a rise on the same cycle, so a
            // gap gets at most one space pulse
            if (cnt_q == WORD_T) begin
               word_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (key_s) begin
               state_d = MARK;
               cnt_d   = ONE;
               char_d  = (cnt_q >= CHAR_T);
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         dot_out        <= 1'b0;
         dash_out       <= 1'b0;
         char_space_out <= 1'b0;
         word_space_out <= 1'b0;
         err_out        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         dot_out        <= dot_d;
         dash_out       <= dash_d;
         char_space_out <= char_d;
         word_space_out <= word_d;
         err_out        <= err_d;
      end
   end

endmodule

// File: tb/tb_mor_key_decoder.sv
// Directed-vector bench for mor_key_decoder with UNIT_CYCLES=4.
// Pulses are logged with cycle stamps and compared per scenario.
module tb_mor_key_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_in = 1'b0;
   logic dot_out, dash_out, char_space_out, word_space_out, err_out;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int ovl = 0;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t log_q[$];

   localparam int K_DOT  = 0;
   localparam int K_DASH = 1;
   localparam int K_CHAR = 2;
   localparam int K_WORD = 3;
   localparam int K_ERR  = 4;

   mor_key_decoder #(.UNIT_CYCLES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .key_in         (key_in),
      .dot_out        (dot_out),
      .dash_out       (dash_out),
      .char_space_out (char_space_out),
      .word_space_out (word_space_out),
      .err_out        (err_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if ($countones({dot_out, dash_out, char_space_out,
                      word_space_out, err_out}) > 1)
         ovl++;
      if (dot_out)        log_q.push_back('{K_DOT, cyc});
      if (dash_out)       log_q.push_back('{K_DASH, cyc});
      if (char_space_out) log_q.push_back('{K_CHAR, cyc});
      if (word_space_out) log_q.push_back('{K_WORD, cyc});
      if (err_out)        log_q.push_back('{K_ERR, cyc});
   end

   task automatic hold(input logic v, input int n);
      key_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int base;
      rst = 1'b0;
      key_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({dot_out, dash_out, char_space_out, word_space_out,
              err_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outs got %b want 00000",
                     {dot_out, dash_out, char_space_out,
                      word_space_out, err_out});
         end
      end
      @(posedge clk);
      #1;
      base = log_q.size();
      rst = 1'b1;
      hold(1'b0, 10);
      total++;
      if (log_q.size() !== base) begin
         bad++;
         $display("FAIL reset_quiet got %0d pulses want 0",
                  log_q.size() - base);
      end
   endtask

   task automatic test_boundary_marks();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 1);  f = cyc; ek.push_back(K_DOT);  ec.push_back(f + 3);
      hold(1'b0, 3);
      hold(1'b1, 7);  f = cyc; ek.push_back(K_DOT);  ec.push_back(f + 3);
      hold(1'b0, 3);
      hold(1'b1, 8);  f = cyc; ek.push_back(K_DASH); ec.push_back(f + 3);
      hold(1'b0, 3);
      hold(1'b1, 27); f = cyc; ek.push_back(K_DASH); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL boundary count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL boundary ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL boundary ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   task automatic test_overlong();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 28); f = cyc; ek.push_back(K_ERR); ec.push_back(f + 3);
      hold(1'b0, 8);  f = cyc; ek.push_back(K_CHAR); ec.push_back(f + 3);
      hold(1'b1, 4);  f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL overlong count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL overlong ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL overlong ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   task automatic test_gaps();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      hold(1'b0, 7);
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      hold(1'b0, 8);
      f = cyc; ek.push_back(K_CHAR); ec.push_back(f + 3);
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      hold(1'b0, 19);
      f = cyc; ek.push_back(K_CHAR); ec.push_back(f + 3);
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 70);
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL gaps count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL gaps ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL gaps ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   task automatic test_letter_a();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 4);  f = cyc; ek.push_back(K_DOT);  ec.push_back(f + 3);
      hold(1'b0, 4);
      hold(1'b1, 12); f = cyc; ek.push_back(K_DASH); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL letter_a count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL letter_a ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL letter_a ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   task automatic test_reset_mark();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 10);
      rst = 1'b0;
      hold(1'b1, 2);
      rst = 1'b1;
      hold(1'b1, 12); f = cyc; ek.push_back(K_DASH); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL reset_mark count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL reset_mark ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL reset_mark ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   task automatic test_reset_gap();
      int base, f;
      int ek[$], ec[$];
      base = log_q.size();
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      // Gap counter sits at 15 after edge f+17
      hold(1'b0, 17);
      rst = 1'b0;
      hold(1'b0, 2);
      rst = 1'b1;
      hold(1'b0, 30);
      hold(1'b1, 4); f = cyc; ek.push_back(K_DOT); ec.push_back(f + 3);
      ek.push_back(K_WORD); ec.push_back(f + 23);
      hold(1'b0, 30);
      total++;
      if (log_q.size() - base !== ek.size()) begin
         bad++;
         $display("FAIL reset_gap count got %0d want %0d",
                  log_q.size() - base, ek.size());
      end
      for (int i = 0; i < ek.size(); i++) begin
         total++;
         if (base + i >= log_q.size()) begin
            bad++;
            $display("FAIL reset_gap ev%0d got none want k%0d@%0d",
                     i, ek[i], ec[i]);
         end else if (log_q[base+i].kind !== ek[i] ||
                      log_q[base+i].cyc !== ec[i]) begin
            bad++;
            $display("FAIL reset_gap ev%0d got k%0d@%0d want k%0d@%0d",
                     i, log_q[base+i].kind, log_q[base+i].cyc,
                     ek[i], ec[i]);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_boundary_marks();
      test_overlong();
      test_gaps();
      test_letter_a();
      test_reset_mark();
      test_reset_gap();
      total++;
      if (ovl !== 0) begin
         bad++;
         $display("FAIL overlap got %0d cycles want 0", ovl);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
